l2_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate L2 cache; responder to the L1 miss/write-through request interface
//  (l1_read_req/l1_write_req ... l1_read_ready/l1_write_ready).

---
 rtl/l2_cache.sv | 250 +++++++++++++++++++++++++
 tb/tb_l2_cache.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache.sv
// l2_cache: direct-mapped, write-back, write-allocate L2 cache that serves L1
// read/write requests and talks to main memory for write-backs and fills.
// Each line holds one DATA_WIDTH word, and all addresses are word addresses.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   l1_read_req/_write_req level requests from L1, held until the matching ready
//   l1_address/_write_data request word address and write data
//   l1_read_data          read data, valid while l1_read_ready is high
//   l1_read/write_ready   one-cycle completion pulses
//   mem_req/_we/_addr/_wdata  memory request (held until mem_ack); we=1 is a write-back
//   mem_rdata, mem_ack    fill data and one-cycle completion pulse
//   hit_count/miss_count  wrapping 32-bit counts of L1 request hits and misses
module l2_cache #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_LINES   = 1024,
    parameter int unsigned HIT_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  l1_read_req,
    input  logic                  l1_write_req,
    input  logic [ADDR_WIDTH-1:0] l1_address,
    input  logic [DATA_WIDTH-1:0] l1_write_data,
    output logic [DATA_WIDTH-1:0] l1_read_data,
    output logic                  l1_read_ready,
    output logic                  l1_write_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W;
    localparam int unsigned CNT_W = (HIT_LATENCY > 1) ? $clog2(HIT_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  op_we_q, op_we_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [NUM_LINES-1:0]  dirty_q, dirty_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_rdy_q, rd_rdy_d;
    logic                  wr_rdy_q, wr_rdy_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;

    // Line storage: tags and data need no reset, valid/dirty gate their use.
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES];

    logic [IDX_W-1:0]      idx_c;
    logic [TAG_W-1:0]      tag_c;
    logic [TAG_W-1:0]      vic_tag_c;
    logic [DATA_WIDTH-1:0] vic_data_c;
    logic                  hit_c;
    logic                  line_we_c;
    logic [DATA_WIDTH-1:0] line_data_c;

    // Lookup of the latched request against the indexed line.
    always_comb begin
        idx_c      = addr_q[IDX_W-1:0];
        tag_c      = addr_q[ADDR_WIDTH-1:IDX_W];
        vic_tag_c  = tag_q[idx_c];
        vic_data_c = data_q[idx_c];
        hit_c      = valid_q[idx_c] && (vic_tag_c == tag_c);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_we_d     = op_we_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        rd_data_d   = rd_data_q;
        rd_rdy_d    = 1'b0;
        wr_rdy_d    = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        line_we_c   = 1'b0;
        line_data_c = wdata_q;

        case (state_q)
            S_IDLE: begin
                // Skip the cycle in which the previous ready pulse is still visible,
                // since L1 has not yet had a chance to drop its request.
                if (!rd_rdy_q && !wr_rdy_q && (l1_write_req || l1_read_req)) begin
                    addr_d  = l1_address;
                    wdata_d = l1_write_data;
                    op_we_d = l1_write_req;
                    cnt_d   = CNT_W'(HIT_LATENCY - 1);
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (hit_c) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                    if (op_we_q) begin
                        line_we_c        = 1'b1;
                        dirty_d[idx_c]   = 1'b1;
                    end else begin
                        rd_data_d = vic_data_c;
                    end
                    state_d = S_RESP;
                end else begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    if (valid_q[idx_c] && dirty_q[idx_c]) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {vic_tag_c, idx_c};
                        mem_wdata_d = vic_data_c;
                        state_d     = S_WB;
                    end else if (!op_we_q) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_q;
                        state_d    = S_FILL;
                    end else begin
                        line_we_c      = 1'b1;
                        valid_d[idx_c] = 1'b1;
                        dirty_d[idx_c] = 1'b1;
                        state_d        = S_RESP;
                    end
                end
            end
            S_WB: begin
                if (mem_req_q && mem_ack) begin
                    mem_req_d      = 1'b0;
                    dirty_d[idx_c] = 1'b0;
                    if (op_we_q) begin
                        line_we_c      = 1'b1;
                        valid_d[idx_c] = 1'b1;
                        dirty_d[idx_c] = 1'b1;
                        state_d        = S_RESP;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                // After a write-back the request is low for one cycle before the fill issues.
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                end else if (mem_ack) begin
                    mem_req_d      = 1'b0;
                    line_we_c      = 1'b1;
                    line_data_c    = mem_rdata;
                    valid_d[idx_c] = 1'b1;
                    dirty_d[idx_c] = 1'b0;
                    rd_data_d      = mem_rdata;
                    state_d        = S_RESP;
                end
            end
            S_RESP: begin
                wr_rdy_d = op_we_q;
                rd_rdy_d = !op_we_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_we_q     <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
            rd_data_q   <= '0;
            rd_rdy_q    <= 1'b0;
            wr_rdy_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_we_q     <= op_we_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            rd_data_q   <= rd_data_d;
            rd_rdy_q    <= rd_rdy_d;
            wr_rdy_q    <= wr_rdy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Line tag/data write port, always at the latched index.
    always_ff @(posedge clk) begin
        if (!reset && line_we_c) begin
            tag_q[idx_c]  <= tag_c;
            data_q[idx_c] <= line_data_c;
        end
    end

    assign l1_read_data   = rd_data_q;
    assign l1_read_ready  = rd_rdy_q;
    assign l1_write_ready = wr_rdy_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache: directed and random transactions against l2_cache. The memory
// model runs alongside the bench, and a reference cache model works per
// transaction, tracking the full address held in each line.
module tb_l2_cache;

    localparam int unsigned NL     = 1024;
    localparam int unsigned HL     = 2;
    localparam int          BUDGET = 60;

    logic        clk;
    logic        reset;
    logic        l1_read_req;
    logic        l1_write_req;
    logic [31:0] l1_address;
    logic [31:0] l1_write_data;
    logic [31:0] l1_read_data;
    logic        l1_read_ready;
    logic        l1_write_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    l2_cache #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_LINES  (NL),
        .HIT_LATENCY(HL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .l1_read_req   (l1_read_req),
        .l1_write_req  (l1_write_req),
        .l1_address    (l1_address),
        .l1_write_data (l1_write_data),
        .l1_read_data  (l1_read_data),
        .l1_read_ready (l1_read_ready),
        .l1_write_ready(l1_write_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main memory contents and the log of memory operations seen.
    logic [31:0] backing [logic [31:0]];
    logic [31:0] wb_a_q[$];
    logic [31:0] wb_d_q[$];
    logic [31:0] fill_a_q[$];
    int          mem_delay = 0;
    bit          mem_hold  = 1'b0;

    // Reference cache state: full address per line rather than a tag.
    bit          m_valid [NL];
    bit          m_dirty [NL];
    logic [31:0] m_addr  [NL];
    logic [31:0] m_data  [NL];
    int unsigned m_hits   = 0;
    int unsigned m_misses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return a * 32'h9E37_79B9 + 32'h1;
    endfunction

    // Memory responder: acks each request after mem_delay cycles; checks stability meanwhile.
    logic [31:0] r_a, r_d;
    bit          r_we, r_ok;
    int          r_k;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                r_a = mem_addr; r_d = mem_wdata; r_we = mem_we; r_k = 0; r_ok = 1'b1;
                while (r_ok && (r_k < mem_delay || mem_hold)) begin
                    @(negedge clk);
                    r_k++;
                    if (mem_req !== 1'b1) r_ok = 1'b0;
                    else begin
                        chk("mem_addr_stable", mem_addr, r_a);
                        chk("mem_we_stable", 32'(mem_we), 32'(r_we));
                        if (r_we) chk("mem_wdata_stable", mem_wdata, r_d);
                    end
                end
                if (r_ok) begin
                    if (r_we) begin
                        wb_a_q.push_back(r_a);
                        wb_d_q.push_back(r_d);
                        backing[r_a] = r_d;
                    end else begin
                        fill_a_q.push_back(r_a);
                        mem_rdata = mem_val(r_a);
                    end
                    mem_ack = 1'b1;
                end
            end
        end
    end

    task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                output bit hit, output bit wb, output logic [31:0] wba,
                                output logic [31:0] wbd, output bit fill, output logic [31:0] rd);
        int i;
        i    = int'(a & 32'(NL - 1));
        hit  = m_valid[i] && (m_addr[i] == a);
        wb   = 1'b0; fill = 1'b0; wba = '0; wbd = '0;
        if (hit) begin
            m_hits++;
            if (we) begin m_data[i] = wd; m_dirty[i] = 1'b1; end
        end else begin
            m_misses++;
            if (m_valid[i] && m_dirty[i]) begin
                wb = 1'b1; wba = m_addr[i]; wbd = m_data[i];
            end
            m_valid[i] = 1'b1;
            m_addr[i]  = a;
            if (we) begin
                m_data[i] = wd; m_dirty[i] = 1'b1;
            end else begin
                fill = 1'b1; m_data[i] = mem_val(a); m_dirty[i] = 1'b0;
            end
        end
        rd = m_data[i];
    endtask

    task automatic wait_ready(input string t, input bit scramble, output int n,
                              output bit got_rd, output bit got_wr);
        bit done;
        done = 1'b0; n = 0; got_rd = 1'b0; got_wr = 1'b0;
        while (!done && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
            if (l1_read_ready || l1_write_ready) begin
                done = 1'b1; got_rd = l1_read_ready; got_wr = l1_write_ready;
            end else if (scramble) begin
                l1_address    = $urandom;
                l1_write_data = $urandom;
            end
        end
        chk({t, " ready_seen"}, 32'(done), 32'd1);
    endtask

    task automatic check_logs(input string t, input bit e_wb, input logic [31:0] wba,
                              input logic [31:0] wbd, input bit e_fill, input logic [31:0] fa);
        chk({t, " wb_n"}, 32'(wb_a_q.size()), 32'(e_wb));
        if (e_wb && wb_a_q.size() > 0) begin
            chk({t, " wb_addr"}, wb_a_q[0], wba);
            chk({t, " wb_data"}, wb_d_q[0], wbd);
        end
        chk({t, " fill_n"}, 32'(fill_a_q.size()), 32'(e_fill));
        if (e_fill && fill_a_q.size() > 0) chk({t, " fill_addr"}, fill_a_q[0], fa);
        chk({t, " hit_count"}, hit_count, m_hits);
        chk({t, " miss_count"}, miss_count, m_misses);
        wb_a_q.delete(); wb_d_q.delete(); fill_a_q.delete();
    endtask

    task automatic pulse_end(input string t);
        @(posedge clk); #1;
        chk({t, " pulse_end"}, 32'({l1_read_ready, l1_write_ready}), 32'd0);
    endtask

    task automatic run_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input bit scramble, input string t);
        bit e_hit, e_wb, e_fill, gr, gw;
        logic [31:0] e_wba, e_wbd, e_rd;
        int n;
        model_access(we, a, wd, e_hit, e_wb, e_wba, e_wbd, e_fill, e_rd);
        @(negedge clk);
        l1_address = a; l1_write_data = wd;
        l1_write_req = we; l1_read_req = !we;
        wait_ready(t, scramble, n, gr, gw);
        l1_read_req = 1'b0; l1_write_req = 1'b0;
        chk({t, " rd_rdy"}, 32'(gr), 32'(!we));
        chk({t, " wr_rdy"}, 32'(gw), 32'(we));
        if (!we) chk({t, " rdata"}, l1_read_data, e_rd);
        if (e_hit) chk({t, " hit_latency"}, 32'(n), 32'(HL + 2));
        check_logs(t, e_wb, e_wba, e_wbd, e_fill, a);
        pulse_end(t);
    endtask

    initial begin
        bit e_hit, e_wb, e_fill, gr, gw;
        logic [31:0] e_wba, e_wbd, e_rd, a;
        int n, k;

        reset = 1'b1; l1_read_req = 1'b0; l1_write_req = 1'b0;
        l1_address = '0; l1_write_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("reset rdata", l1_read_data, 32'd0);
        chk("reset readies", 32'({l1_read_ready, l1_write_ready}), 32'd0);
        chk("reset mem_req", 32'({mem_req, mem_we}), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset hits", hit_count, 32'd0);
        chk("reset misses", miss_count, 32'd0);

        // Clean read miss, then a read hit on the same address.
        backing[32'h10] = 32'hA5A5_0001;
        mem_delay = 3;
        run_txn(1'b0, 32'h10, 32'h0, 1'b0, "read_miss_0x10");
        chk("read_miss_0x10 const_data", l1_read_data, 32'hA5A5_0001);
        chk("read_miss_0x10 const_miss", miss_count, 32'd1);
        run_txn(1'b0, 32'h10, 32'h0, 1'b0, "read_hit_0x10");
        chk("read_hit_0x10 const_hit", hit_count, 32'd1);

        // Write hit makes the line dirty; a conflicting read writes it back.
        run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, "write_hit_0x10");
        mem_delay = 2;
        run_txn(1'b0, 32'h10 + NL, 32'h0, 1'b0, "dirty_evict_0x410");
        chk("evict backing", backing[32'h10], 32'hDEAD_BEEF);

        // Write miss to an invalid line needs no memory; its later eviction writes it back.
        run_txn(1'b1, 32'h20, 32'h0000_1234, 1'b0, "write_miss_0x20");
        run_txn(1'b0, 32'h20 + NL, 32'h0, 1'b0, "evict_0x20");
        chk("evict_0x20 backing", backing[32'h20], 32'h0000_1234);

        // Both requests high: the write completes first, then the read sees the written data.
        model_access(1'b1, 32'h30, 32'h5555_AAAA, e_hit, e_wb, e_wba, e_wbd, e_fill, e_rd);
        @(negedge clk);
        l1_address = 32'h30; l1_write_data = 32'h5555_AAAA;
        l1_write_req = 1'b1; l1_read_req = 1'b1;
        wait_ready("both_w", 1'b0, n, gr, gw);
        l1_write_req = 1'b0;
        chk("both_w wr_rdy", 32'(gw), 32'd1);
        chk("both_w rd_rdy", 32'(gr), 32'd0);
        check_logs("both_w", e_wb, e_wba, e_wbd, e_fill, 32'h30);
        pulse_end("both_w");
        model_access(1'b0, 32'h30, 32'h0, e_hit, e_wb, e_wba, e_wbd, e_fill, e_rd);
        wait_ready("both_r", 1'b0, n, gr, gw);
        l1_read_req = 1'b0;
        chk("both_r rd_rdy", 32'(gr), 32'd1);
        chk("both_r rdata", l1_read_data, 32'h5555_AAAA);
        chk("both_r hit_latency", 32'(n), 32'(HL + 2));
        check_logs("both_r", e_wb, e_wba, e_wbd, e_fill, 32'h30);
        pulse_end("both_r");

        // Reset while a write-back is outstanding discards the dirty line.
        run_txn(1'b1, 32'h50, 32'hCAFE_F00D, 1'b0, "rst_setup");
        mem_hold = 1'b1;
        @(negedge clk);
        l1_address = 32'h50 + NL; l1_read_req = 1'b1;
        k = 0;
        while (mem_req !== 1'b1 && k < BUDGET) begin
            @(posedge clk); #1; k++;
        end
        chk("rst wb_req", 32'(mem_req), 32'd1);
        chk("rst wb_we", 32'(mem_we), 32'd1);
        chk("rst wb_addr", mem_addr, 32'h50);
        @(negedge clk); reset = 1'b1; l1_read_req = 1'b0;
        @(posedge clk); #1;
        chk("rst mem_req_drop", 32'(mem_req), 32'd0);
        chk("rst no_ready", 32'({l1_read_ready, l1_write_ready}), 32'd0);
        @(negedge clk); reset = 1'b0; mem_hold = 1'b0;
        for (int i = 0; i < int'(NL); i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
        m_hits = 0; m_misses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst quiet", 32'({l1_read_ready, l1_write_ready, mem_req}), 32'd0);
        end
        chk("rst counters", hit_count | miss_count, 32'd0);
        wb_a_q.delete(); wb_d_q.delete(); fill_a_q.delete();
        run_txn(1'b0, 32'h50, 32'h0, 1'b0, "rst_reread_0x50");
        chk("rst discarded", 32'(backing.exists(32'h50)), 32'd0);

        // Random traffic over a few conflicting lines; inputs scrambled after capture.
        for (int t = 0; t < 60; t++) begin
            mem_delay = $urandom_range(0, 4);
            a = 32'($urandom_range(0, 3)) * NL + 32'h100 + 32'($urandom_range(0, 3));
            run_txn(1'($urandom_range(0, 1)), a, $urandom, 1'b1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
